// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with registered outputs
module uart_tx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Active,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_CLEANUP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    byte_q, byte_d;
  logic          serial_q, serial_d;
  logic          active_q, active_d;
  logic          done_q, done_d;

  // Next-state logic; outputs are computed for the state being entered so
  // that the registered line level changes on the same edge as the state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    byte_d   = byte_q;
    serial_d = serial_q;
    active_d = active_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        serial_d = 1'b1;
        active_d = 1'b0;
        cnt_d    = '0;
        idx_d    = '0;
        if (i_Tx_DV) begin
          byte_d   = i_Tx_Byte;
          state_d  = S_START;
          serial_d = 1'b0;
          active_d = 1'b1;
        end
      end

      S_START: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d    = '0;
          idx_d    = '0;
          state_d  = S_DATA;
          serial_d = byte_q[0];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            state_d  = S_STOP;
            serial_d = 1'b1;
          end else begin
            idx_d    = idx_q + 3'd1;
            serial_d = byte_q[idx_q + 3'd1];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d    = '0;
          state_d  = S_CLEANUP;
          serial_d = 1'b1;
          active_d = 1'b0;
          done_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_CLEANUP: begin
        state_d  = S_IDLE;
        serial_d = 1'b1;
        active_d = 1'b0;
      end

      default: begin
        state_d  = S_IDLE;
        cnt_d    = '0;
        idx_d    = '0;
        serial_d = 1'b1;
        active_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any frame and idles the line.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      byte_q   <= '0;
      serial_q <= 1'b1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      byte_q   <= byte_d;
      serial_q <= serial_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  assign o_Tx_Serial = serial_q;
  assign o_Tx_Active = active_q;
  assign o_Tx_Done   = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx at N=87 and N=2
module tb_uart_tx;

  localparam int N1 = 87;
  localparam int N2 = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       dv1, dv2;
  logic [7:0] byte1, byte2;
  logic       act1, ser1, done1;
  logic       act2, ser2, done2;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(N1)) dut (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv1), .i_Tx_Byte(byte1),
    .o_Tx_Active(act1), .o_Tx_Serial(ser1), .o_Tx_Done(done1)
  );

  uart_tx #(.CLKS_PER_BIT(N2)) dut2 (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv2), .i_Tx_Byte(byte2),
    .o_Tx_Active(act2), .o_Tx_Serial(ser2), .o_Tx_Done(done2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Receiver: called just after the accepting edge E0; samples after each
  // edge E0+i for i = 0..10n+1 and records the frame as seen on the line.
  task automatic watch(input bit sel, input int n, output logic [9:0] bits,
                       output int glitches, output int act, output int dcnt,
                       output int dat);
    logic lvl, s, a, d;
    bits = '0; glitches = 0; act = 0; dcnt = 0; dat = -1; lvl = 1'b1;
    for (int i = 0; i < 10*n + 2; i++) begin
      if (i > 0) @(posedge clk);
      @(negedge clk);
      s = sel ? ser2 : ser1;
      a = sel ? act2 : act1;
      d = sel ? done2 : done1;
      if (a) act++;
      if (d) begin
        dcnt++;
        if (dat < 0) dat = i;
      end
      if (i < 10*n) begin
        if (i % n == 0) lvl = s;
        else if (s !== lvl) glitches++;
        if (i % n == n/2) bits[i/n] = s;
      end else if (s !== 1'b1) begin
        glitches++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; dv1 = 1'b0; dv2 = 1'b0; byte1 = 8'h00; byte2 = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (ser1 !== 1'b1 || act1 !== 1'b0 || done1 !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d: serial=%b active=%b done=%b, required 1 0 0",
                 i, ser1, act1, done1);
      end
    end
    tick();
  endtask

  task automatic test_single_ab();
    logic [9:0] bits; logic [7:0] e;
    int gl, act, dc, dat;
    byte1 = 8'hAB; dv1 = 1'b1; exp_q.push_back(8'hAB);
    tick();
    dv1 = 1'b0;
    watch(1'b0, N1, bits, gl, act, dc, dat);
    e = exp_q.pop_front();
    checks += 5;
    if (bits !== {1'b1, e, 1'b0}) begin errors++; $display("FAIL ab_bits: got %b, required %b", bits, {1'b1, e, 1'b0}); end
    if (gl != 0) begin errors++; $display("FAIL ab_bit_width: %0d off-level samples, required 0", gl); end
    if (act != 10*N1) begin errors++; $display("FAIL ab_active: %0d cycles, required %0d", act, 10*N1); end
    if (dc != 1) begin errors++; $display("FAIL ab_done_count: %0d, required 1", dc); end
    if (dat != 10*N1) begin errors++; $display("FAIL ab_done_time: E0+%0d, required E0+%0d", dat, 10*N1); end
    tick();
  endtask

  task automatic test_ignore_midframe();
    logic [9:0] bits; logic [7:0] e;
    int gl, act, dc, dat;
    byte1 = 8'hAB; dv1 = 1'b1; exp_q.push_back(8'hAB);
    tick();
    dv1 = 1'b0;
    fork
      watch(1'b0, N1, bits, gl, act, dc, dat);
      begin
        repeat (300) tick();
        byte1 = 8'h00; dv1 = 1'b1;
        tick();
        dv1 = 1'b0;
      end
    join
    e = exp_q.pop_front();
    checks += 3;
    if (bits !== {1'b1, e, 1'b0}) begin errors++; $display("FAIL mid_bits: got %b, required %b", bits, {1'b1, e, 1'b0}); end
    if (gl != 0) begin errors++; $display("FAIL mid_bit_width: %0d off-level samples, required 0", gl); end
    if (dc != 1) begin errors++; $display("FAIL mid_done_count: %0d, required 1", dc); end
    repeat (N1 * 2) begin
      @(negedge clk);
      checks++;
      if (act1 !== 1'b0) begin errors++; $display("FAIL mid_no_queue: active=%b, required 0", act1); end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [9:0] bits; logic [7:0] e;
    int gl, act, dc, dat;
    byte1 = 8'h00; dv1 = 1'b1;
    exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
    tick();
    byte1 = 8'hFF;
    for (int f = 0; f < 2; f++) begin
      if (f == 1) tick();
      watch(1'b0, N1, bits, gl, act, dc, dat);
      if (f == 1) dv1 = 1'b0;
      e = exp_q.pop_front();
      checks += 4;
      if (bits !== {1'b1, e, 1'b0}) begin errors++; $display("FAIL b2b_bits f%0d: got %b, required %b", f, bits, {1'b1, e, 1'b0}); end
      if (gl != 0) begin errors++; $display("FAIL b2b_bit_width f%0d: %0d off-level samples, required 0", f, gl); end
      if (act != 10*N1) begin errors++; $display("FAIL b2b_active f%0d: %0d, required %0d", f, act, 10*N1); end
      if (dat != 10*N1 || dc != 1) begin errors++; $display("FAIL b2b_done f%0d: at %0d count %0d, required at %0d count 1", f, dat, dc, 10*N1); end
    end
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (act1 !== 1'b0) begin errors++; $display("FAIL b2b_third: active=%b, required 0", act1); end
    end
    tick();
  endtask

  task automatic test_reset_midframe();
    logic [9:0] bits; logic [7:0] e;
    int gl, act, dc, dat;
    byte1 = 8'h55; dv1 = 1'b1;
    tick();
    dv1 = 1'b0;
    repeat (5*N1 + 40) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ser1 !== 1'b1 || act1 !== 1'b0) begin errors++; $display("FAIL abort_line: serial=%b active=%b, required 1 0", ser1, act1); end
    dc = 0;
    for (int i = 0; i < 12*N1; i++) begin
      @(negedge clk);
      if (done1 === 1'b1) dc++;
      if (ser1 !== 1'b1) dc += 1000;
    end
    checks++;
    if (dc != 0) begin errors++; $display("FAIL abort_quiet: score %0d, required 0", dc); end
    // Request coincident with reset is discarded.
    tick();
    rst = 1'b1; dv1 = 1'b1; byte1 = 8'hC3;
    tick();
    rst = 1'b0; dv1 = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (act1 !== 1'b0) begin errors++; $display("FAIL reset_dv: active=%b, required 0", act1); end
    end
    tick();
    byte1 = 8'h3F; dv1 = 1'b1; exp_q.push_back(8'h3F);
    tick();
    dv1 = 1'b0;
    watch(1'b0, N1, bits, gl, act, dc, dat);
    e = exp_q.pop_front();
    checks += 3;
    if (bits !== {1'b1, e, 1'b0}) begin errors++; $display("FAIL post_reset_bits: got %b, required %b", bits, {1'b1, e, 1'b0}); end
    if (gl != 0) begin errors++; $display("FAIL post_reset_width: %0d off-level samples, required 0", gl); end
    if (dat != 10*N1 || dc != 1) begin errors++; $display("FAIL post_reset_done: at %0d count %0d, required at %0d count 1", dat, dc, 10*N1); end
    tick();
  endtask

  task automatic test_min_n();
    logic [9:0] bits; logic [7:0] e;
    int gl, act, dc, dat;
    byte2 = 8'h80; dv2 = 1'b1; exp_q.push_back(8'h80);
    tick();
    dv2 = 1'b0;
    watch(1'b1, N2, bits, gl, act, dc, dat);
    e = exp_q.pop_front();
    checks += 4;
    if (bits !== {1'b1, e, 1'b0}) begin errors++; $display("FAIL n2_bits: got %b, required %b", bits, {1'b1, e, 1'b0}); end
    if (gl != 0) begin errors++; $display("FAIL n2_bit_width: %0d off-level samples, required 0", gl); end
    if (act != 10*N2) begin errors++; $display("FAIL n2_active: %0d, required %0d", act, 10*N2); end
    if (dat != 10*N2 || dc != 1) begin errors++; $display("FAIL n2_done: at %0d count %0d, required at %0d count 1", dat, dc, 10*N2); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_ab();
    test_ignore_midframe();
    test_back_to_back();
    test_reset_midframe();
    test_min_n();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d left, required 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter: accepts one byte per handshake and shifts it out as an 8N1 frame (one start bit, 8 data bits LSB first, one stop bit, no parity) at a baud rate set by a clocks-per-bit parameter. It sits between a byte-wide producer (CPU or FSM) and the TX pin. It reports busy (`o_Tx_Active`) and a one-cycle completion strobe (`o_Tx_Done`).

## Interface
- `CLKS_PER_BIT`, default 87: clock cycles per serial bit (10 MHz / 115200 baud). Legal range is ≥ 2.
- `i_Clock` input, 1 bit: the single clock; all logic is on its rising edge.
- `i_Reset` input, 1 bit: synchronous, active-high reset.
- `i_Tx_DV` input, 1 bit: data valid; a one-cycle request to transmit `i_Tx_Byte`.
- `i_Tx_Byte` input, 8 bits: byte to send, sampled on the accepting edge.
- `o_Tx_Active` output, 1 bit: high while a frame (start, data, stop) is being driven.
- `o_Tx_Serial` output, 1 bit: TX line; idle high.
- `o_Tx_Done` output, 1 bit: one-cycle pulse after the stop bit completes.

## Operation
- States:
  - IDLE: line = 1, Active = 0, Done = 0. On an edge with `i_Tx_DV` = 1, latch `i_Tx_Byte` into an internal register, go to START and clear the counters.
  - START: line = 0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - DATA: line = latched bit[index] for `CLKS_PER_BIT` cycles per bit. The index runs 0..7; after bit 7, go to STOP.
  - STOP: line = 1 for `CLKS_PER_BIT` cycles, then go to CLEANUP.
  - CLEANUP: one cycle with line = 1, Active = 0, Done = 1. Then go to IDLE.
- Active = 1 in START, DATA and STOP only.
- `i_Tx_DV` is ignored in every state except IDLE; no queuing. `i_Tx_Byte` changes after acceptance do not affect the frame.
- The clock counter counts 0..`CLKS_PER_BIT`-1 and is sized `$clog2(CLKS_PER_BIT)`. The bit index is 3 bits.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset (synchronous, priority over everything):
  - State = IDLE, counters = 0, latched byte = 0.
  - `o_Tx_Serial` = 1, `o_Tx_Active` = 0, `o_Tx_Done` = 0 after the reset edge.
  - Reset mid-frame aborts the frame immediately: line high, no Done pulse.

## Timing
- Let E0 be the edge that samples `i_Tx_DV` = 1 in IDLE. N = `CLKS_PER_BIT`.
- After E0: Serial = 0, Active = 1.
- Data bit k is driven from edge E0+(k+1)·N to E0+(k+2)·N, for k = 0..7.
- Stop bit is driven from E0+9N to E0+10N.
- After E0+10N: Active = 0, Done = 1, Serial = 1.
- After E0+10N+1: Done = 0, state IDLE.
- The earliest next acceptance edge is E0+10N+2. Minimum request spacing is 10N+2 cycles.
- `i_Tx_DV` held high continuously produces back-to-back frames at that spacing.
- DV asserted on the same edge as reset is discarded.

## Test plan
- Power-up reset, then idle for 20 cycles -> Serial = 1, Active = 0, Done = 0 throughout.
- N = 87, send 0xAB (DV pulsed for one cycle) -> the following values, then a single 1-cycle Done at E0+870:
  - line samples at bit centres: 0 (start), 1,1,0,1,0,1,0,1 (data, LSB first), 1 (stop);
  - each bit exactly 87 cycles;
  - Active high for exactly 870 cycles.
- Change `i_Tx_Byte` to 0x00 and pulse DV mid-frame of 0xAB -> frame unchanged; exactly one Done pulse.
- Send 0x00 then 0xFF with DV held high -> two frames; second start bit at E0+872; data bits all 0, then all 1.
- Assert reset during data bit 4 of 0x55 -> line = 1 and Active = 0 after the reset edge; no Done pulse; a new 0x3F request afterwards transmits correctly.
- N = 2, send 0x80 -> frame 20 cycles long; data bit 7 high only; Done at E0+20.
